// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-select stage.
// Source-mode encodings and operand-pair sizing helper.
package alu_pkg;

    localparam int ALU_SEL_W = 2;

    localparam logic [ALU_SEL_W-1:0] ALU_SEL_RI = 2'b00;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_RR = 2'b01;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_PI = 2'b10;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_R0 = 2'b11;

    // Operand pair is packed as {alu_a, alu_b}.
    function automatic int alu_pair_w(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Request/response bundle for the ALU operand-select stage.
// master drives requests and accepts operands; slave is the stage.
interface alu_operand_stage_if #(
    parameter int DWIDTH = 16,
    parameter int IMM_W  = 8
);
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [ALU_SEL_W-1:0] alu_in_sel;
    logic                 imm_sext;
    logic [DWIDTH-1:0]    rd_q;
    logic [DWIDTH-1:0]    rs_q;
    logic [DWIDTH-1:0]    pc_q;
    logic [IMM_W-1:0]     offset;
    logic                 out_valid;
    logic                 out_ready;
    logic [DWIDTH-1:0]    alu_a;
    logic [DWIDTH-1:0]    alu_b;

    modport master (
        output in_valid, alu_in_sel, imm_sext,
        output rd_q, rs_q, pc_q, offset,
        output out_ready,
        input  in_ready, out_valid, alu_a, alu_b
    );

    modport slave (
        input  in_valid, alu_in_sel, imm_sext,
        input  rd_q, rs_q, pc_q, offset,
        input  out_ready,
        output in_ready, out_valid, alu_a, alu_b
    );

endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid: output register plus one skid slot.
// Ready is registered (skid empty) so upstream never sees a comb path.
module alu_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         ov_q;
    logic [W-1:0] od_q;
    logic         sv_q;
    logic [W-1:0] sd_q;
    logic         rdy_q;
    logic         accept;
    logic         drain;

    assign in_ready  = rdy_q & ~rst;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign accept    = in_valid & in_ready;
    assign drain     = ov_q & out_ready;

    // Output/skid occupancy: skid only fills when output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q  <= 1'b0;
            od_q  <= '0;
            sv_q  <= 1'b0;
            sd_q  <= '0;
            rdy_q <= 1'b1;
        end else if (sv_q) begin
            if (drain) begin
                od_q  <= sd_q;
                sv_q  <= 1'b0;
                rdy_q <= 1'b1;
            end
        end else if (accept) begin
            if (!ov_q || drain) begin
                od_q <= in_data;
                ov_q <= 1'b1;
            end else begin
                sd_q  <= in_data;
                sv_q  <= 1'b1;
                rdy_q <= 1'b0;
            end
        end else if (drain) begin
            ov_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand select with valid/ready skid and stall counter.
// Optional operand forwarding ports enabled by ALU_OPERAND_FWD_EN.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int IMM_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_operand_stage_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt
`ifdef ALU_OPERAND_FWD_EN
    ,
    input  logic              fwd_valid,
    input  logic [DWIDTH-1:0] fwd_data,
    input  logic              fwd_a,
    input  logic              fwd_b
`endif
);

    localparam int PW = alu_pair_w(DWIDTH);

    logic [DWIDTH-1:0] imm_ext;
    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b;
    logic [PW-1:0]     pair_d;
    logic [PW-1:0]     pair_q;
    logic              out_valid;
    logic              in_ready;

    assign imm_ext = {{(DWIDTH-IMM_W){bus.imm_sext & bus.offset[IMM_W-1]}},
                      bus.offset};

    // Source select; forwarding only touches the pair being accepted.
    always_comb begin
        op_a = bus.rd_q;
        op_b = imm_ext;
        unique case (bus.alu_in_sel)
            ALU_SEL_RI: begin
                op_a = bus.rd_q;
                op_b = imm_ext;
            end
            ALU_SEL_RR: begin
                op_a = bus.rd_q;
                op_b = bus.rs_q;
            end
            ALU_SEL_PI: begin
                op_a = bus.pc_q;
                op_b = imm_ext;
            end
            ALU_SEL_R0: begin
                op_a = bus.rd_q;
                op_b = '0;
            end
        endcase
`ifdef ALU_OPERAND_FWD_EN
        if (fwd_valid && fwd_a)
            op_a = fwd_data;
        if (fwd_valid && fwd_b && bus.alu_in_sel == ALU_SEL_RR)
            op_b = fwd_data;
`endif
    end

    assign pair_d = {op_a, op_b};

    alu_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .in_data   (pair_d),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (pair_q)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.alu_a     = pair_q[PW-1:DWIDTH];
    assign bus.alu_b     = pair_q[DWIDTH-1:0];

    // Saturating count of cycles the ALU back-pressures a valid pair.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !bus.out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Registered ALU operand-select stage that replaces the single-bit reg/imm operand mux with a parametrised, flow-controlled successor.
- Sits between register-file read and the ALU.
- Selects A/B from register, PC or immediate sources, and zero- or sign-extends the immediate.
- Uses a valid/ready handshake with a 2-entry skid buffer so ALU back-pressure never drops an operand pair.

Parameters:
- DWIDTH, 16: datapath width of all operands.
- IMM_W, 8: immediate (offset) width; legal range is 1 to DWIDTH-1.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  stage can accept a request.
- alu_in_sel  in  2  source mode (see Behaviour).
- imm_sext  in  1  1 = sign-extend offset, 0 = zero-extend.
- rd_q  in  DWIDTH  destination/first register value.
- rs_q  in  DWIDTH  source/second register value.
- pc_q  in  DWIDTH  current PC.
- offset  in  IMM_W  immediate.
- out_valid  out  1  alu_a/alu_b valid.
- out_ready  in  1  ALU accepts the operand pair.
- alu_a  out  DWIDTH  operand A.
- alu_b  out  DWIDTH  operand B.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst; all state updates on posedge clk only.
- Reset values: out_valid=0, alu_a=0, alu_b=0, stall_cnt=0, skid entry empty. in_ready=0 while rst=1 and 1 on the first cycle after rst drops.
- Mode decode, combinational on the input side:
  - 2'b00 RI: A=rd_q, B=ext(offset).
  - 2'b01 RR: A=rd_q, B=rs_q.
  - 2'b10 PI: A=pc_q, B=ext(offset).
  - 2'b11 R0: A=rd_q, B=0.
- Extension:
  - ext() zero-extends offset to DWIDTH when imm_sext=0.
  - ext() replicates offset[IMM_W-1] into the upper DWIDTH-IMM_W bits when imm_sext=1.
  - imm_sext is ignored in modes 01 and 11.
- Accept: a transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle. An accepted pair appears on alu_a/alu_b with out_valid=1 on the next edge when the output register is empty or is draining in the same cycle.
- Skid behaviour:
  - If the output register holds an undrained pair (out_valid=1, out_ready=0) and a new pair is accepted, the new pair goes to the skid entry.
  - in_ready is registered and equals "skid entry empty"; it drops on the edge that fills the skid.
  - When the output drains and the skid is full, the skid pair moves to the output register on that edge. The skid empties and in_ready returns to 1 on the same edge.
  - With the skid full, the input accepts nothing; in_valid is a don't-care.
- Simultaneous accept + drain with the skid empty: the output register loads the new pair and out_valid stays 1. There is no bubble, and throughput is 1 pair per cycle.
- Ordering: strictly FIFO. No pair is dropped or duplicated.
- alu_a/alu_b hold their last value when out_valid=0. No X is driven after reset.
- stall_cnt increments each cycle out_valid && !out_ready and saturates at all-ones (no wrap).
- Reset mid-operation: both entries are discarded. out_valid=0 on the next edge and stall_cnt is cleared.

Optional Feature:
- Macro: ALU_OPERAND_FWD_EN.
- When defined, adds these ports:
  - fwd_valid (in, 1)
  - fwd_data (in, DWIDTH)
  - fwd_a (in, 1)
  - fwd_b (in, 1)
- With the feature, at accept time:
  - If fwd_valid && fwd_a, A=fwd_data, overriding the mode source.
  - If fwd_valid && fwd_b and the mode is 01, B=fwd_data.
  - Forwarding applies only to the pair being accepted; skid contents are never rewritten.
- Without the macro, the ports are absent and operands come only from the mode decode.

Decomposition:
- Package alu_pkg holds:
  - localparams ALU_SEL_RI=2'b00, ALU_SEL_RR=2'b01, ALU_SEL_PI=2'b10, ALU_SEL_R0=2'b11.
  - A shared operand-pair struct/width constant for {alu_a, alu_b}.
- One sub-module: alu_skid_buf, a generic 2-entry valid/ready skid of width 2*DWIDTH.
- The top level holds the mode decode, extension, forwarding and stall_cnt.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, alu_a=alu_b=0, stall_cnt=0, in_ready=0 during reset and 1 on the next cycle.
- Modes (DWIDTH=16, IMM_W=8, out_ready=1), with rd_q=16'h1234, rs_q=16'h00FF, pc_q=16'h0100:
  - sel=00, offset=8'h80, imm_sext=0 -> A=16'h1234, B=16'h0080 one cycle later.
  - sel=00, imm_sext=1 -> B=16'hFF80.
  - sel=10, imm_sext=1 -> A=16'h0100, B=16'hFF80.
  - sel=01 -> B=16'h00FF.
  - sel=11 -> B=16'h0000.
- Back-pressure: stream pairs P0,P1,P2 with out_ready=0 from cycle 1 -> P0 held on output, P1 in skid, in_ready=0, P2 not accepted, stall_cnt counts up by 1 per cycle. Raise out_ready -> P0,P1,P2 emerge in order, no loss.
- Full throughput: in_valid=out_ready=1 for 10 cycles with incrementing rd_q -> 10 consecutive out_valid cycles, in_ready never drops.
- Saturation: CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt sticks at 4'hF.
- Reset mid-stream (skid full) -> out_valid=0 next edge, the stalled pairs never appear. With ALU_OPERAND_FWD_EN, fwd_valid=1, fwd_a=1, fwd_data=16'hBEEF -> A=16'hBEEF.
